jtag_ir_dr: RTL and testbench
=============================

# jtag_ir_dr

JTAG instruction- and data-register block that sits directly downstream of the `jtag` TAP controller. It consumes the TAP's registered state and TDI. It then captures, shifts and updates a 4-bit instruction register and the selected data register: IDCODE, BYPASS or an 8-bit USER register. It produces the TDO bit for the shift states. The USER register gives the rest of the design a simple JTAG-writable/readable word.

## Interface
Parameters:
- `IR_WIDTH`, 4: instruction register width.
- `IDCODE_VALUE`, 32'h0000_FAF0: value captured into the 32-bit IDCODE DR.
- `USER_WIDTH`, 8: USER data register width.

Ports:
- `tck`  in  1: the only clock. All state changes on rising edge.
- `trst`  in  1: reset, synchronous, active-high.
- `tap_state`  in  5: TAP `current_state`, same encoding as the TAP controller. TestLogicReset=0x00, CaptureDr=0x04, CaptureIr=0x05, ShiftDr=0x06, ShiftIr=0x07, UpdateDr=0x14, UpdateIr=0x15. All other codes mean hold.
- `tdi`  in  1: serial data in.
- `tdo`  out  1: serial data out (combinational from internal registers).
- `tdo_en`  out  1: high while `tap_state` is ShiftIr or ShiftDr.
- `ir_out`  out  IR_WIDTH: currently active (updated) instruction.
- `user_capture`  in  USER_WIDTH: value loaded into USER DR at CaptureDr.
- `user_update`  out  USER_WIDTH: last USER DR value committed at UpdateDr.
- `user_update_valid`  out  1: one-cycle pulse when `user_update` is written.

## Operation
- Instruction codes: IDCODE=4'b0001, USER=4'b0010, BYPASS=4'b1111.
- Any other code selects BYPASS behaviour. `ir_out` still reports the raw code.
- Registers: `ir_shift[IR_WIDTH]`, `ir[IR_WIDTH]`, `id_dr[32]`, `user_dr[USER_WIDTH]`, `bypass_dr[1]`, `user_update`, `user_update_valid`.
- On each `tck` edge with `trst` low, the action is chosen by the `tap_state` value present before the edge:
  - TestLogicReset: `ir` <= IDCODE. Shift registers hold.
  - CaptureIr: `ir_shift` <= {0…0,2'b01} (IEEE-mandated LSBs 01).
  - ShiftIr: `ir_shift` <= {tdi, ir_shift[IR_WIDTH-1:1]}.
  - UpdateIr: `ir` <= `ir_shift`.
  - CaptureDr: IDCODE selected -> `id_dr` <= IDCODE_VALUE. USER -> `user_dr` <= `user_capture`. BYPASS/other -> `bypass_dr` <= 0.
  - ShiftDr: only the selected DR shifts right, with `tdi` into its MSB. Unselected DRs hold.
  - UpdateDr: USER selected -> `user_update` <= `user_dr`, `user_update_valid` <= 1. Otherwise no effect.
  - Any other state: hold.
- `user_update_valid` is 0 on every edge not described above.
- TDO mux:
  - ShiftIr: `tdo` = `ir_shift[0]`.
  - ShiftDr: `tdo` = LSB of the selected DR (`id_dr[0]`, `user_dr[0]`, `bypass_dr`).
  - Otherwise `tdo` = 0.
- `tdo_en` mirrors the shift-state decode.
- `ir` changes only at UpdateIr or TestLogicReset. A DR selection is stable for a whole Capture/Shift/Update sequence.

## Timing
- Reset (`trst`=1 at an edge): `ir`=IDCODE, `ir_shift`=0, `id_dr`=0, `user_dr`=0, `bypass_dr`=0, `user_update`=0, `user_update_valid`=0. `tdo`=0 and `tdo_en`=0 while `tap_state` is not a shift state.
- `trst` has priority over every state action, including mid-ShiftDr/ShiftIr. Partially shifted data is discarded and `user_update` is not written.
- Latency:
  - `tdo` is valid in the same cycle `tap_state` enters a shift state; the first bit is the captured LSB.
  - Each ShiftDr/ShiftIr cycle presents the next bit.
  - BYPASS delays `tdi` to `tdo` by exactly one shift cycle.
  - `ir_out` changes one edge after UpdateIr.
  - `user_update`/`user_update_valid` change one edge after UpdateDr.
- Shift counts are unbounded. Over-shifting a DR of N bits passes `tdi` through with an N-cycle delay.
- Pause/Exit states hold all registers, so a shift resumes seamlessly after Exit2->Shift.
- An unknown `tap_state` encoding holds all registers.

## Test plan
- Reset then CaptureDr + 32×ShiftDr, `tdi`=1 -> `tdo` emits 0xFAF0 LSB-first (0,0,0,0,1,1,1,1,0,1,0,1,1,1,1,1, then 16 zeros); `tdo_en`=1 throughout.
- CaptureIr + 4×ShiftIr with `tdi`=1,1,1,1 + UpdateIr -> `tdo`=1,0,0,0; `ir_out`=4'hF on the edge after UpdateIr.
- With BYPASS loaded: CaptureDr + ShiftDr, `tdi`=1,0,1,1 -> `tdo`=0,1,0,1 (one-cycle delay).
- Load USER, `user_capture`=8'h3C. Capture + 8×ShiftDr with `tdi`=bits of 8'hA5 LSB-first + UpdateDr:
  - `tdo` = 8'h3C LSB-first.
  - `user_update`=8'hA5, with a `user_update_valid` pulse exactly one cycle wide.
- Load unknown IR 4'h7 -> `ir_out`=7; DR shifts behave as BYPASS; UpdateDr gives no `user_update_valid`.
- Assert `trst` midway through a USER ShiftDr -> `ir_out`=IDCODE and `user_update` stays 0. The next Capture/Shift returns IDCODE.

Source files
------------

// File: rtl/jtag_ir_dr.sv
// rtl/jtag_ir_dr.sv - JTAG instruction register plus IDCODE/BYPASS/USER data registers
// Driven by the TAP controller's registered state; produces TDO for the shift states.
module jtag_ir_dr #(
    parameter int unsigned IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_FAF0,
    parameter int unsigned USER_WIDTH   = 8
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic [4:0]            tap_state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic [USER_WIDTH-1:0] user_capture,
    output logic [USER_WIDTH-1:0] user_update,
    output logic                  user_update_valid
);

    localparam logic [4:0] ST_TEST_LOGIC_RESET = 5'h00;
    localparam logic [4:0] ST_CAPTURE_DR       = 5'h04;
    localparam logic [4:0] ST_CAPTURE_IR       = 5'h05;
    localparam logic [4:0] ST_SHIFT_DR         = 5'h06;
    localparam logic [4:0] ST_SHIFT_IR         = 5'h07;
    localparam logic [4:0] ST_UPDATE_DR        = 5'h14;
    localparam logic [4:0] ST_UPDATE_IR        = 5'h15;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
    // The capture pattern happens to equal IDCODE's encoding: LSBs 01, rest zero.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
    logic [31:0]           id_dr_q, id_dr_d;
    logic [USER_WIDTH-1:0] user_dr_q, user_dr_d;
    logic                  bypass_q, bypass_d;
    logic [USER_WIDTH-1:0] user_update_q, user_update_d;
    logic                  user_update_valid_q, user_update_valid_d;

    logic sel_idcode;
    logic sel_user;
    logic in_shift_ir;
    logic in_shift_dr;

    // Every code other than IDCODE and USER falls back to BYPASS.
    assign sel_idcode  = (ir_q == IR_IDCODE);
    assign sel_user    = (ir_q == IR_USER);
    assign in_shift_ir = (tap_state == ST_SHIFT_IR);
    assign in_shift_dr = (tap_state == ST_SHIFT_DR);

    always_comb begin
        ir_d                = ir_q;
        ir_shift_d          = ir_shift_q;
        id_dr_d             = id_dr_q;
        user_dr_d           = user_dr_q;
        bypass_d            = bypass_q;
        user_update_d       = user_update_q;
        user_update_valid_d = 1'b0;

        case (tap_state)
            ST_TEST_LOGIC_RESET: begin
                ir_d = IR_IDCODE;
            end
            ST_CAPTURE_IR: begin
                ir_shift_d = IR_CAPTURE;
            end
            ST_SHIFT_IR: begin
                ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            end
            ST_UPDATE_IR: begin
                ir_d = ir_shift_q;
            end
            ST_CAPTURE_DR: begin
                if (sel_idcode) begin
                    id_dr_d = IDCODE_VALUE;
                end else if (sel_user) begin
                    user_dr_d = user_capture;
                end else begin
                    bypass_d = 1'b0;
                end
            end
            ST_SHIFT_DR: begin
                if (sel_idcode) begin
                    id_dr_d = {tdi, id_dr_q[31:1]};
                end else if (sel_user) begin
                    user_dr_d = {tdi, user_dr_q[USER_WIDTH-1:1]};
                end else begin
                    bypass_d = tdi;
                end
            end
            ST_UPDATE_DR: begin
                if (sel_user) begin
                    user_update_d       = user_dr_q;
                    user_update_valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge tck) begin
        if (trst) begin
            ir_q                <= IR_IDCODE;
            ir_shift_q          <= '0;
            id_dr_q             <= '0;
            user_dr_q           <= '0;
            bypass_q            <= 1'b0;
            user_update_q       <= '0;
            user_update_valid_q <= 1'b0;
        end else begin
            ir_q                <= ir_d;
            ir_shift_q          <= ir_shift_d;
            id_dr_q             <= id_dr_d;
            user_dr_q           <= user_dr_d;
            bypass_q            <= bypass_d;
            user_update_q       <= user_update_d;
            user_update_valid_q <= user_update_valid_d;
        end
    end

    // TDO is combinational so the captured LSB appears in the first shift cycle.
    always_comb begin
        tdo = 1'b0;
        if (in_shift_ir) begin
            tdo = ir_shift_q[0];
        end else if (in_shift_dr) begin
            if (sel_idcode) begin
                tdo = id_dr_q[0];
            end else if (sel_user) begin
                tdo = user_dr_q[0];
            end else begin
                tdo = bypass_q;
            end
        end
    end

    assign tdo_en            = in_shift_ir | in_shift_dr;
    assign ir_out            = ir_q;
    assign user_update       = user_update_q;
    assign user_update_valid = user_update_valid_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// tb/tb_jtag_ir_dr.sv - self-checking bench for jtag_ir_dr
module tb_jtag_ir_dr;

    localparam logic [4:0] ST_TLR  = 5'h00;
    localparam logic [4:0] ST_IDLE = 5'h01;
    localparam logic [4:0] ST_CDR  = 5'h04;
    localparam logic [4:0] ST_CIR  = 5'h05;
    localparam logic [4:0] ST_SDR  = 5'h06;
    localparam logic [4:0] ST_SIR  = 5'h07;
    localparam logic [4:0] ST_UDR  = 5'h14;
    localparam logic [4:0] ST_UIR  = 5'h15;
    localparam logic [4:0] ST_P1   = 5'h03;
    localparam logic [4:0] ST_P2   = 5'h13;
    localparam logic [31:0] IDCODE = 32'h0000_FAF0;

    logic       tck = 1'b0;
    logic       trst;
    logic [4:0] tap_state;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir_out;
    logic [7:0] user_capture;
    logic [7:0] user_update;
    logic       user_update_valid;

    int tests_run    = 0;
    int tests_failed = 0;
    logic exp_q[$];

    jtag_ir_dr dut (
        .tck               (tck),
        .trst              (trst),
        .tap_state         (tap_state),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .ir_out            (ir_out),
        .user_capture      (user_capture),
        .user_update       (user_update),
        .user_update_valid (user_update_valid)
    );

    always #5 tck = ~tck;

    // Drive one TAP cycle, sampling tdo/tdo_en before the rising edge.
    task automatic cycle(input logic [4:0] st, input logic d, output logic o, output logic en);
        tap_state = st;
        tdi       = d;
        #2;
        o  = tdo;
        en = tdo_en;
        @(posedge tck);
        #1;
    endtask

    task automatic step(input logic [4:0] st);
        logic o, en;
        cycle(st, 1'b0, o, en);
    endtask

    task automatic load_ir(input logic [3:0] code, input logic [3:0] prev);
        logic o, en, e;
        step(ST_CIR);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(i == 0);
            cycle(ST_SIR, code[i], o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e || en !== 1'b1) begin
                tests_failed++;
                $display("FAIL ir_tdo[%0d] got tdo=%b en=%b exp tdo=%b en=1", i, o, en, e);
            end
        end
        tests_run++;
        if (ir_out !== prev) begin
            tests_failed++;
            $display("FAIL ir_before_update got %h exp %h", ir_out, prev);
        end
        step(ST_UIR);
        tests_run++;
        if (ir_out !== code) begin
            tests_failed++;
            $display("FAIL ir_after_update got %h exp %h", ir_out, code);
        end
        step(ST_IDLE);
    endtask

    task automatic test_reset();
        trst = 1'b1;
        tap_state = ST_IDLE;
        tdi = 1'b0;
        user_capture = 8'h00;
        @(posedge tck); #1;
        @(posedge tck); #1;
        trst = 1'b0;
        #1;
        tests_run++;
        if (ir_out !== 4'h1) begin tests_failed++; $display("FAIL rst_ir got %h exp 1", ir_out); end
        tests_run++;
        if (user_update !== 8'h00) begin tests_failed++; $display("FAIL rst_uu got %h exp 00", user_update); end
        tests_run++;
        if (user_update_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_uv got %b exp 0", user_update_valid); end
        tests_run++;
        if (tdo !== 1'b0) begin tests_failed++; $display("FAIL rst_tdo got %b exp 0", tdo); end
        tests_run++;
        if (tdo_en !== 1'b0) begin tests_failed++; $display("FAIL rst_tdo_en got %b exp 0", tdo_en); end
    endtask

    task automatic test_idcode(input logic d);
        logic o, en, e;
        step(ST_CDR);
        for (int i = 0; i < 33; i++) begin
            // 33rd bit: the first tdi shifted in has reached the LSB.
            exp_q.push_back(i < 32 ? IDCODE[i] : d);
            cycle(ST_SDR, d, o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e || en !== 1'b1) begin
                tests_failed++;
                $display("FAIL id_tdo[%0d] got tdo=%b en=%b exp tdo=%b en=1", i, o, en, e);
            end
        end
        cycle(ST_IDLE, 1'b0, o, en);
        tests_run++;
        if (o !== 1'b0 || en !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_tdo got tdo=%b en=%b exp 0/0", o, en);
        end
    endtask

    task automatic test_bypass();
        logic o, en, e, prev;
        logic [3:0] pat;
        pat = 4'b1101;
        load_ir(4'hF, 4'h1);
        step(ST_CDR);
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(prev);
            prev = pat[i];
            cycle(ST_SDR, pat[i], o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL byp_tdo[%0d] got %b exp %b", i, o, e);
            end
        end
        step(ST_IDLE);
    endtask

    task automatic test_user();
        logic o, en, e;
        logic [7:0] wr, cap;
        wr  = 8'hA5;
        cap = 8'h3C;
        load_ir(4'h2, 4'hF);
        user_capture = cap;
        step(ST_CDR);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                step(ST_P1);
                step(ST_P2);
            end
            exp_q.push_back(cap[i]);
            cycle(ST_SDR, wr[i], o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL user_tdo[%0d] got %b exp %b", i, o, e);
            end
        end
        tests_run++;
        if (user_update_valid !== 1'b0) begin tests_failed++; $display("FAIL uv_early got %b exp 0", user_update_valid); end
        step(ST_UDR);
        tests_run++;
        if (user_update !== wr) begin tests_failed++; $display("FAIL uu got %h exp %h", user_update, wr); end
        tests_run++;
        if (user_update_valid !== 1'b1) begin tests_failed++; $display("FAIL uv_pulse got %b exp 1", user_update_valid); end
        step(ST_IDLE);
        tests_run++;
        if (user_update_valid !== 1'b0) begin tests_failed++; $display("FAIL uv_width got %b exp 0", user_update_valid); end
        tests_run++;
        if (user_update !== wr) begin tests_failed++; $display("FAIL uu_hold got %h exp %h", user_update, wr); end
    endtask

    task automatic test_unknown_ir();
        logic o, en, e, prev;
        logic [2:0] pat;
        pat = 3'b011;
        load_ir(4'h7, 4'h2);
        step(ST_CDR);
        prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(prev);
            prev = pat[i];
            cycle(ST_SDR, pat[i], o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL unk_tdo[%0d] got %b exp %b", i, o, e);
            end
        end
        step(ST_UDR);
        tests_run++;
        if (user_update_valid !== 1'b0) begin tests_failed++; $display("FAIL unk_uv got %b exp 0", user_update_valid); end
        tests_run++;
        if (user_update !== 8'hA5) begin tests_failed++; $display("FAIL unk_uu got %h exp a5", user_update); end
        step(ST_IDLE);
    endtask

    task automatic test_trst_mid_shift();
        logic o, en, e;
        logic [7:0] cap;
        cap = 8'h55;
        load_ir(4'h2, 4'h7);
        user_capture = cap;
        step(ST_CDR);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(cap[i]);
            cycle(ST_SDR, 1'b1, o, en);
            e = exp_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL trst_tdo[%0d] got %b exp %b", i, o, e);
            end
        end
        trst = 1'b1;
        step(ST_SDR);
        trst = 1'b0;
        tests_run++;
        if (ir_out !== 4'h1) begin tests_failed++; $display("FAIL trst_ir got %h exp 1", ir_out); end
        tests_run++;
        if (user_update !== 8'h00) begin tests_failed++; $display("FAIL trst_uu got %h exp 00", user_update); end
        step(ST_UDR);
        tests_run++;
        if (user_update_valid !== 1'b0 || user_update !== 8'h00) begin
            tests_failed++;
            $display("FAIL trst_udr got uv=%b uu=%h exp 0/00", user_update_valid, user_update);
        end
        test_idcode(1'b0);
    endtask

    task automatic test_tlr_restores_idcode();
        load_ir(4'hF, 4'h1);
        step(ST_TLR);
        tests_run++;
        if (ir_out !== 4'h1) begin tests_failed++; $display("FAIL tlr_ir got %h exp 1", ir_out); end
        step(ST_IDLE);
    endtask

    initial begin
        @(posedge tck);
        #1;
        test_reset();
        test_idcode(1'b1);
        test_bypass();
        test_user();
        test_unknown_ir();
        test_trst_mid_shift();
        test_tlr_restores_idcode();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
